// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if: fetch, load/store and RAM signals of mem_port_sched.
// mem_wstrb exists only when MEM_SCHED_BYTE_EN is defined.
interface mem_port_sched_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [1:0]  d_op;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_fault;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_SCHED_BYTE_EN
    logic [3:0]  mem_wstrb;
`endif

    modport slave (
        input  if_req, if_addr, d_req, d_op, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_fault,
        output mem_addr, mem_re, mem_we, mem_wdata
`ifdef MEM_SCHED_BYTE_EN
        , output mem_wstrb
`endif
    );

    modport master (
        output if_req, if_addr, d_req, d_op, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_fault,
        input  mem_addr, mem_re, mem_we, mem_wdata
`ifdef MEM_SCHED_BYTE_EN
        , input mem_wstrb
`endif
    );
endinterface

// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one 1-cycle-latency RAM between fetch and load/store with alignment, extension
// and sub-word read-modify-write; MEM_SCHED_BYTE_EN replaces the RMW with byte-strobed single writes.
module mem_port_sched #(
    parameter int IF_MAX_WAIT = 4,
    parameter int WAIT_W = 3
) (
    input logic clk,
    input logic rst,
    mem_port_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IF_RSP, LD_RSP, ST_WR, ACK} state_t;
    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(IF_MAX_WAIT);

    state_t state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0] f3_q;
    logic fault_q, latch_d, fetch_win, d_load, d_store, d_bad;
    logic [3:0] st_strb;
    logic [31:0] st_mask;

    function automatic logic [31:0] lane_rep(input logic half, input logic [15:0] w);
        return half ? {2{w}} : {4{w[7:0]}};
    endfunction

    function automatic logic [3:0] lane_strb(input logic half, input logic [1:0] l);
        return (half ? 4'b0011 : 4'b0001) << l;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [1:0] l, input logic [31:0] w);
        logic [31:0] s;
        s = w >> {l, 3'b000};
        return f[1] ? w : f[0] ? {{16{s[15] & ~f[2]}}, s[15:0]} : {{24{s[7] & ~f[2]}}, s[7:0]};
    endfunction

    // fetch only overtakes data once it has lost IF_MAX_WAIT arbitrations in a row
    assign fetch_win = bus.if_req && (!bus.d_req || (IF_MAX_WAIT != 0 && wait_cnt == MAX_W));
    assign d_load = bus.d_op == 2'd1;
    assign d_store = bus.d_op == 2'd2;
    assign d_bad = (d_load && (bus.d_funct3 == 3'b011 || bus.d_funct3[2:1] == 2'b11))
                || (d_store && bus.d_funct3 > 3'b010)
                || ((d_load || d_store) && ((bus.d_funct3[1:0] == 2'b01 && bus.d_addr[0])
                    || (bus.d_funct3[1:0] == 2'b10 && bus.d_addr[1:0] != 2'b00)));
    assign st_strb = lane_strb(f3_q[0], addr_q[1:0]);
    assign st_mask = {{8{st_strb[3]}}, {8{st_strb[2]}}, {8{st_strb[1]}}, {8{st_strb[0]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wait_cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            f3_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            wait_cnt <= wait_nx;
            if (latch_d) begin
                addr_q <= bus.d_addr;
                wdata_q <= bus.d_wdata[15:0];
                f3_q <= bus.d_funct3;
                fault_q <= d_bad;
            end
        end
    end

    // every output is forced low while rst is high, whatever the current state
    always_comb begin
        state_nx = state;
        wait_nx = wait_cnt;
        latch_d = 1'b0;
        bus.if_gnt = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_rdata = '0;
        bus.d_gnt = 1'b0;
        bus.d_valid = 1'b0;
        bus.d_rdata = '0;
        bus.d_fault = 1'b0;
        bus.mem_addr = '0;
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_wdata = '0;
`ifdef MEM_SCHED_BYTE_EN
        bus.mem_wstrb = '0;
`endif
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (fetch_win) begin
                        bus.if_gnt = 1'b1;
                        bus.mem_re = 1'b1;
                        bus.mem_addr = bus.if_addr & 32'hFFFF_FFFC;
                        wait_nx = '0;
                        state_nx = IF_RSP;
                    end else if (bus.d_req) begin
                        bus.d_gnt = 1'b1;
                        latch_d = 1'b1;
                        wait_nx = (bus.if_req && wait_cnt != '1) ? wait_cnt + 1'b1 : wait_cnt;
                        bus.mem_addr = bus.d_addr & 32'hFFFF_FFFC;
                        if (d_bad || !(d_load || d_store)) begin
                            state_nx = ACK;
                        end else if (d_load) begin
                            bus.mem_re = 1'b1;
                            state_nx = LD_RSP;
                        end else if (bus.d_funct3 == 3'b010) begin
                            bus.mem_we = 1'b1;
                            bus.mem_wdata = bus.d_wdata;
`ifdef MEM_SCHED_BYTE_EN
                            bus.mem_wstrb = 4'b1111;
`endif
                            state_nx = ACK;
                        end else begin
`ifdef MEM_SCHED_BYTE_EN
                            bus.mem_we = 1'b1;
                            bus.mem_wdata = lane_rep(bus.d_funct3[0], bus.d_wdata[15:0]);
                            bus.mem_wstrb = lane_strb(bus.d_funct3[0], bus.d_addr[1:0]);
                            state_nx = ACK;
`else
                            bus.mem_re = 1'b1;
                            state_nx = ST_WR;
`endif
                        end
                    end
                end
                IF_RSP: begin
                    bus.if_valid = 1'b1;
                    bus.if_rdata = bus.mem_rdata;
                    state_nx = IDLE;
                end
                LD_RSP: begin
                    bus.d_valid = 1'b1;
                    bus.d_rdata = load_ext(f3_q, addr_q[1:0], bus.mem_rdata);
                    state_nx = IDLE;
                end
                ST_WR: begin
                    bus.mem_we = 1'b1;
                    bus.mem_addr = addr_q & 32'hFFFF_FFFC;
                    bus.mem_wdata = (bus.mem_rdata & ~st_mask) | (lane_rep(f3_q[0], wdata_q) & st_mask);
                    state_nx = ACK;
                end
                ACK: begin
                    bus.d_valid = 1'b1;
                    bus.d_fault = fault_q;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule
